// File: rtl/if_stage_bp.sv
// Instruction-fetch PC unit with a direct-mapped BTB and 2-bit saturating
// direction counters; execute trains the BTB and redirects on mispredict.
module if_stage_bp #(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o
);

  localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [XLEN-1:0] pc_q, pc_d;

  logic            valid_q  [BTB_ENTRIES];
  logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0] target_q [BTB_ENTRIES];
  logic [1:0]      ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0]  lk_idx;
  logic [TAGW-1:0] lk_tag;
  logic            lk_hit;

  logic [IDX-1:0]  up_idx;
  logic [TAGW-1:0] up_tag;
  logic            up_hit;
  logic [1:0]      up_ctr;
  logic            upd_we;
  logic [1:0]      upd_ctr_d;
  logic [XLEN-1:0] upd_target_d;

  // Low PC bits are byte offsets within a word and never index the BTB.
  logic unused_upd_lsbs;
  assign unused_upd_lsbs = ^upd_pc_i[1:0];

  // Lookup for the current fetch PC; reads the pre-update BTB contents.
  always_comb begin
    lk_idx        = pc_q[IDX+1:2];
    lk_tag        = pc_q[XLEN-1:IDX+2];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
    pred_target_o = pred_taken_o ? target_q[lk_idx] : '0;
  end

  // Next PC: flush > stall > predicted target > sequential.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (flush_i) begin
      pc_d = redirect_pc_i;
    end else if (stall_i) begin
      pc_d = pc_q;
    end else if (pred_taken_o) begin
      pc_d = pred_target_o;
    end
  end

  // Training: taken allocates or strengthens, not-taken only weakens a hit.
  always_comb begin
    up_idx       = upd_pc_i[IDX+1:2];
    up_tag       = upd_pc_i[XLEN-1:IDX+2];
    up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr       = ctr_q[up_idx];
    upd_we       = 1'b0;
    upd_ctr_d    = up_ctr;
    upd_target_d = target_q[up_idx];
    if (upd_valid_i) begin
      if (upd_taken_i) begin
        upd_we       = 1'b1;
        upd_target_d = upd_target_i;
        if (!up_hit) begin
          upd_ctr_d = CTR_WT;
        end else if (up_ctr != CTR_ST) begin
          upd_ctr_d = 2'(up_ctr + 2'd1);
        end
      end else if (up_hit) begin
        upd_we = 1'b1;
        if (up_ctr != CTR_SNT) begin
          upd_ctr_d = 2'(up_ctr - 2'd1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q <= RESET_PC;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else begin
      pc_q <= pc_d;
      if (upd_we) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target_d;
        ctr_q[up_idx]    <= upd_ctr_d;
      end
    end
  end

  assign pc_o = pc_q;

endmodule

// File: tb/tb_if_stage_bp.sv
// Directed self-checking bench for if_stage_bp (XLEN=32, 16-entry BTB).
module tb_if_stage_bp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_stage_bp #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_pc_i (redirect_pc),
    .upd_valid_i   (upd_valid),
    .upd_pc_i      (upd_pc),
    .upd_target_i  (upd_target),
    .upd_taken_i   (upd_taken),
    .pc_o          (pc),
    .pred_taken_o  (pred_taken),
    .pred_target_o (pred_target)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; redirect_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
  endtask

  // One cycle: optional redirect plus optional training update.
  task automatic cycle(input logic fl, input logic [31:0] rpc, input logic st,
                       input logic uv, input logic [31:0] upc,
                       input logic [31:0] utgt, input logic ut);
    flush = fl; redirect_pc = rpc; stall = st;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = ut;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle_inputs();
    rst_n = 0;
    step();
    step();
    n_checks++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
    rst_n = 1;
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'd4;
      n_checks++;
      if (pc !== exp_pc || pred_taken !== 1'b0) begin
        n_fail++;
        $display("FAIL seq_pc[%0d]: got pc=%h pred=%b want pc=%h pred=0", i, pc, pred_taken, exp_pc);
      end
    end
  endtask

  task automatic test_allocate();
    // pc is 0xC here; update trains 0x20 while fetch walks toward it
    cycle(0, '0, 0, 1, 32'h20, 32'h100, 1);
    for (int i = 0; i < 10 && pc !== 32'h20; i++) step();
    n_checks++;
    if (pc !== 32'h20) begin n_fail++; $display("FAIL alloc_reach: got %h want %h", pc, 32'h20); end
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      n_fail++;
      $display("FAIL alloc_pred: got %b/%h want 1/%h", pred_taken, pred_target, 32'h100);
    end
    step();
    n_checks++;
    if (pc !== 32'h100) begin n_fail++; $display("FAIL alloc_jump: got %h want %h", pc, 32'h100); end
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL alloc_miss: got %b/%h want 0/0", pred_taken, pred_target);
    end
  endtask

  task automatic test_hysteresis();
    // ctr 10 -> 01 on the same edge that lands on 0x20
    cycle(1, 32'h20, 0, 1, 32'h20, 32'h0, 0);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL hyst_weak: got %b/%h want 0/0", pred_taken, pred_target);
    end
    step();
    n_checks++;
    if (pc !== 32'h24) begin n_fail++; $display("FAIL hyst_seq: got %h want %h", pc, 32'h24); end
    cycle(1, 32'h20, 0, 1, 32'h20, 32'h100, 1);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      n_fail++;
      $display("FAIL hyst_retrain: got %b/%h want 1/%h", pred_taken, pred_target, 32'h100);
    end
  endtask

  task automatic test_saturation();
    cycle(1, 32'h40, 0, 0, '0, '0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 1, 32'h20, 32'h100, 1);
    n_checks++;
    if (pc !== 32'h40) begin n_fail++; $display("FAIL sat_stall: got %h want %h", pc, 32'h40); end
    cycle(0, '0, 1, 1, 32'h20, 32'h0, 0);
    cycle(1, 32'h20, 0, 0, '0, '0, 0);
    n_checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      n_fail++;
      $display("FAIL sat_one_nt: got %b/%h want 1/%h", pred_taken, pred_target, 32'h100);
    end
    // lookup uses the pre-update entry while the second not-taken lands
    cycle(0, '0, 0, 1, 32'h20, 32'h0, 0);
    n_checks++;
    if (pc !== 32'h100) begin n_fail++; $display("FAIL same_cycle_lookup: got %h want %h", pc, 32'h100); end
    cycle(1, 32'h20, 0, 0, '0, '0, 0);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL sat_two_nt: got %b/%h want 0/0", pred_taken, pred_target);
    end
    step();
    n_checks++;
    if (pc !== 32'h24) begin n_fail++; $display("FAIL sat_seq: got %h want %h", pc, 32'h24); end
  endtask

  task automatic test_priority();
    cycle(1, 32'h200, 1, 0, '0, '0, 0);
    n_checks++;
    if (pc !== 32'h200) begin n_fail++; $display("FAIL flush_over_stall: got %h want %h", pc, 32'h200); end
    cycle(1, 32'h40, 0, 0, '0, '0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 1, 0, '0, '0, 0);
      n_checks++;
      if (pc !== 32'h40) begin n_fail++; $display("FAIL stall_hold[%0d]: got %h want %h", i, pc, 32'h40); end
    end
    step();
    n_checks++;
    if (pc !== 32'h44) begin n_fail++; $display("FAIL stall_release: got %h want %h", pc, 32'h44); end
  endtask

  task automatic test_alias_wrap();
    cycle(0, '0, 0, 1, 32'h20, 32'h100, 1);
    cycle(1, 32'h60, 0, 0, '0, '0, 0);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL alias_miss: got %b/%h want 0/0", pred_taken, pred_target);
    end
    step();
    n_checks++;
    if (pc !== 32'h64) begin n_fail++; $display("FAIL alias_seq: got %h want %h", pc, 32'h64); end
    cycle(1, 32'h20, 0, 0, '0, '0, 0);
    n_checks++;
    if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_orig: got %b want 1", pred_taken); end
    cycle(1, 32'hFFFF_FFFC, 0, 0, '0, '0, 0);
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL wrap_pred: got %b want 0", pred_taken); end
    step();
    n_checks++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
  endtask

  task automatic test_midstream_reset();
    // 0x20 predicts taken now; reset edge also carries an update that must be dropped
    rst_n = 0;
    cycle(1, 32'h300, 0, 1, 32'h80, 32'h500, 1);
    n_checks++;
    if (pc !== 32'h0 || pred_taken !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_pc: got pc=%h pred=%b want pc=0 pred=0", pc, pred_taken);
    end
    rst_n = 1;
    cycle(1, 32'h20, 0, 0, '0, '0, 0);
    n_checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_cleared: got %b/%h want 0/0", pred_taken, pred_target);
    end
    cycle(1, 32'h80, 0, 0, '0, '0, 0);
    n_checks++;
    if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL midreset_noupd: got %b want 0", pred_taken); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_allocate();
    test_hysteresis();
    test_saturation();
    test_priority();
    test_alias_wrap();
    test_midstream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
